// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU among NREQ requesters
module alu_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_src1,
    input  logic [NREQ*32-1:0]   req_src2,
    input  logic [NREQ*4-1:0]    req_aluc,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_out,
    output logic [3:0]           rsp_flags,
    output logic [31:0]          alu_src1,
    output logic [31:0]          alu_src2,
    output logic [3:0]           alu_aluc,
    input  logic [31:0]          alu_out,
    input  logic                 alu_zero,
    input  logic                 alu_cout,
    input  logic                 alu_overflow,
    input  logic                 alu_sign
);

    localparam int IDX_W = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  owner_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  cand_idx;
    logic [IDX_W-1:0]  rr_next;
    logic              grant_found;
    logic              arb_en;
    logic              accept;
    int                cand;

    logic [31:0]       op_src1_q, op_src2_q;
    logic [3:0]        op_aluc_q;
    logic [31:0]       res_out_q;
    logic [3:0]        res_flags_q;
    logic [31:0]       sel_src1, sel_src2;
    logic [3:0]        sel_aluc;

    // Grants only happen while idle or while the current owner completes its response;
    // rst_n gating keeps req_ready low for the whole reset window.
    assign arb_en = rst_n &&
                    ((state_q == IDLE) || ((state_q == RESP) && rsp_ready[owner_q]));

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand     = (int'(rr_ptr_q) + k) % NREQ;
            cand_idx = IDX_W'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign accept  = arb_en && grant_found;
    assign rr_next = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_src1 = '0;
        sel_src2 = '0;
        sel_aluc = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_src1 = req_src1[32*i +: 32];
                sel_src2 = req_src2[32*i +: 32];
                sel_aluc = req_aluc[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: state_d = RESP;
            RESP: if (rsp_ready[owner_q]) state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            op_src1_q   <= '0;
            op_src2_q   <= '0;
            op_aluc_q   <= '0;
            res_out_q   <= '0;
            res_flags_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_src1_q <= sel_src1;
                op_src2_q <= sel_src2;
                op_aluc_q <= sel_aluc;
                owner_q   <= grant_idx;
                rr_ptr_q  <= rr_next;
            end
            // The ALU is combinational, so its result is valid during the single EXEC cycle.
            if (state_q == EXEC) begin
                res_out_q   <= alu_out;
                res_flags_q <= {alu_zero, alu_cout, alu_overflow, alu_sign};
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    assign rsp_out   = res_out_q;
    assign rsp_flags = res_flags_q;
    assign alu_src1  = op_src1_q;
    assign alu_src2  = op_src2_q;
    assign alu_aluc  = op_aluc_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [63:0]  req_src1;
    logic [63:0]  req_src2;
    logic [7:0]   req_aluc;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [31:0]  rsp_out;
    logic [3:0]   rsp_flags;
    logic [31:0]  alu_src1, alu_src2;
    logic [3:0]   alu_aluc;
    logic [31:0]  alu_out;
    logic         alu_zero, alu_cout, alu_overflow, alu_sign;

    int n_cmp = 0;
    int n_bad = 0;

    alu_arbiter #(.NREQ(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_src1     (req_src1),
        .req_src2     (req_src2),
        .req_aluc     (req_aluc),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_out      (rsp_out),
        .rsp_flags    (rsp_flags),
        .alu_src1     (alu_src1),
        .alu_src2     (alu_src2),
        .alu_aluc     (alu_aluc),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .alu_cout     (alu_cout),
        .alu_overflow (alu_overflow),
        .alu_sign     (alu_sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // add: cout = carry out; sub: cout = borrow; other opcodes return 0
    logic [32:0] sum33;
    always_comb begin
        sum33        = '0;
        alu_out      = '0;
        alu_cout     = 1'b0;
        alu_overflow = 1'b0;
        case (alu_aluc)
            4'b0000: begin
                sum33        = {1'b0, alu_src1} + {1'b0, alu_src2};
                alu_out      = sum33[31:0];
                alu_cout     = sum33[32];
                alu_overflow = (alu_src1[31] == alu_src2[31]) && (sum33[31] != alu_src1[31]);
            end
            4'b0001: begin
                alu_out      = alu_src1 - alu_src2;
                alu_cout     = alu_src1 < alu_src2;
                alu_overflow = (alu_src1[31] != alu_src2[31]) && (alu_out[31] != alu_src1[31]);
            end
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == 32'd0);
        alu_sign = alu_out[31];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req_src1[32*r +: 32] = a;
        req_src2[32*r +: 32] = b;
        req_aluc[4*r +: 4]   = op;
    endtask

    // One operation on requester r with rsp_ready held high, starting from IDLE
    task automatic single_op(input string tag, input int r, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] op, input logic [31:0] exp_out, input logic [3:0] exp_flags);
        set_req(r, a, b, op);
        req_valid    = 2'b00;
        req_valid[r] = 1'b1;
        rsp_ready    = 2'b11;
        #1;
        check({tag, "_grant"}, 64'(req_ready), 64'(req_valid));
        tick();
        req_valid = 2'b00;
        check({tag, "_exec_src1"}, 64'(alu_src1), 64'(a));
        check({tag, "_exec_nvalid"}, 64'(rsp_valid), 64'd0);
        tick();
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(2'b01 << r));
        check({tag, "_rsp_out"}, 64'(rsp_out), 64'(exp_out));
        check({tag, "_rsp_flags"}, 64'(rsp_flags), 64'(exp_flags));
        tick();
        check({tag, "_idle"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'($urandom);
        rsp_ready = 2'($urandom);
        req_src1  = {$urandom, $urandom};
        req_src2  = {$urandom, $urandom};
        req_aluc  = 8'($urandom);
        repeat (3) tick();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp", 64'({rsp_out, rsp_flags}), 64'd0);
        check("rst_alu_src", 64'({alu_src1, alu_src2}), 64'd0);
        check("rst_alu_aluc", 64'(alu_aluc), 64'd0);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("post_rst_out", 64'({rsp_out, rsp_flags, alu_aluc}), 64'd0);

        single_op("add", 0, 32'd5, 32'd7, 4'b0000, 32'd12, 4'b0000);
        single_op("ovf", 1, 32'h7FFF_FFFF, 32'd1, 4'b0000, 32'h8000_0000, 4'b0011);
        single_op("sub", 1, 32'd3, 32'd3, 4'b0001, 32'd0, 4'b1000);
        single_op("undef", 0, 32'd9, 32'd4, 4'b1111, 32'd0, 4'b1000);

        // Round-robin: rr_ptr is 1 here (last grant went to requester 0)
        set_req(0, 32'd10, 32'd1, 4'b0000);
        set_req(1, 32'd20, 32'd2, 4'b0001);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        check("rr_c0_grant", 64'(req_ready), 64'(2'b10));
        tick();
        check("rr_c1_grant", 64'(req_ready), 64'd0);
        tick();
        check("rr_c2_valid", 64'(rsp_valid), 64'(2'b10));
        check("rr_c2_out", 64'(rsp_out), 64'd18);
        check("rr_c2_grant", 64'(req_ready), 64'(2'b01));
        tick();
        check("rr_c3_grant", 64'(req_ready), 64'd0);
        tick();
        check("rr_c4_valid", 64'(rsp_valid), 64'(2'b01));
        check("rr_c4_out", 64'(rsp_out), 64'd11);
        check("rr_c4_grant", 64'(req_ready), 64'(2'b10));
        tick();
        tick();
        check("rr_c6_valid", 64'(rsp_valid), 64'(2'b10));
        check("rr_c6_grant", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = 2'b00;
        tick();
        check("rr_c8_valid", 64'(rsp_valid), 64'(2'b01));
        check("rr_c8_out", 64'(rsp_out), 64'd11);
        tick();
        check("rr_c9_idle", 64'(rsp_valid), 64'd0);

        // Backpressure: rr_ptr is 1 (last grant requester 0), so requester 1 wins first
        set_req(0, 32'd100, 32'd50, 4'b0001);
        set_req(1, 32'd40, 32'd2, 4'b0000);
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        #1;
        check("bp_grant1", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = 2'b01;
        tick();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) rsp_ready = 2'b01;
            #1;
            check("bp_hold_valid", 64'(rsp_valid), 64'(2'b10));
            check("bp_hold_out", 64'(rsp_out), 64'd42);
            check("bp_hold_ready", 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = 2'b10;
        #1;
        check("bp_release_grant", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = 2'b00;
        check("bp_next_exec_src1", 64'(alu_src1), 64'd100);
        check("bp_next_exec_nvalid", 64'(rsp_valid), 64'd0);
        rsp_ready = 2'b01;
        tick();
        check("bp_next_rsp", 64'({rsp_valid, rsp_out}), {30'd0, 2'b01, 32'd50});
        tick();

        // Reset during EXEC
        set_req(0, 32'hDEAD_0000, 32'h0000_BEEF, 4'b0000);
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        tick();
        req_valid = 2'b00;
        check("mid_exec_src1", 64'(alu_src1), 64'hDEAD_0000);
        rst_n = 1'b0;
        #1;
        check("mid_rst_alu", 64'({alu_src1, alu_src2}), 64'd0);
        check("mid_rst_aluc", 64'(alu_aluc), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("mid_rst_no_rsp", 64'(rsp_valid), 64'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 32-bit ALU between NREQ requesters (e.g. the core datapath and a debug/test port) using a per-requester valid/ready handshake. Round-robin arbitration selects one request, registers its operands onto the ALU inputs, captures the ALU result and flags, and returns them to the owning requester. It sits between the requesters and the ALU instance and is the only driver of the ALU's src1/src2/aluc inputs.

## Interface
- NREQ, default 2: number of requesters, legal range 2..4.
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  request i presents an operation.
- req_ready  output  NREQ  request i accepted this cycle; at most one bit set.
- req_src1  input  NREQ*32  operand 1, requester i in bits [32i+31:32i].
- req_src2  input  NREQ*32  operand 2, same packing.
- req_aluc  input  NREQ*4  ALU opcode, requester i in bits [4i+3:4i].
- rsp_valid  output  NREQ  result for requester i held valid; at most one bit set.
- rsp_ready  input  NREQ  requester i takes the result.
- rsp_out  output  32  result, shared by all requesters, qualified by rsp_valid.
- rsp_flags  output  4  {zero, cout, overflow, sign}, shared, qualified by rsp_valid.
- alu_src1, alu_src2  output  32 each  registered ALU operands.
- alu_aluc  output  4  registered ALU opcode.
- alu_out  input  32  ALU result.
- alu_zero, alu_cout, alu_overflow, alu_sign  input  1 each  ALU flags.

## Operation
- States: IDLE, EXEC, RESP. Registers: state, owner (clog2(NREQ) bits), rr_ptr (clog2(NREQ) bits), operand regs (32+32+4), result regs (32+4).
- Arbitration (combinational, only when state is IDLE, or RESP with rsp_valid[owner] && rsp_ready[owner]): winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ. req_ready[winner]=1, all other req_ready bits 0. No valid request: req_ready all 0.
- Accept (edge where req_valid[w] && req_ready[w]): operand regs <= requester w's src1/src2/aluc; owner <= w; rr_ptr <= (w+1) mod NREQ; state <= EXEC.
- EXEC: alu_* outputs driven from operand regs. On the edge, result regs <= {alu_out, alu_zero, alu_cout, alu_overflow, alu_sign}; state <= RESP. Exactly one EXEC cycle, no stall.
- RESP: rsp_valid[owner]=1; rsp_out/rsp_flags from result regs, stable until handshake. On edge with rsp_ready[owner]: if a new request is accepted that cycle go to EXEC, else IDLE. rsp_ready bits of non-owners are ignored.
- Without handshake in RESP: stay in RESP, no grants, all req_ready 0.
- Opcodes are forwarded unchanged, including undefined values (ALU returns 0; flags passed through as reported).
- Requesters hold req_valid and operands stable until req_ready; deasserting req_valid earlier simply withdraws the request (never granted).

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert by the system): state IDLE, owner 0, rr_ptr 0, operand and result regs 0. So alu_src1/alu_src2/alu_aluc = 0, rsp_out = 0, rsp_flags = 0, rsp_valid = 0, req_ready = 0 until first post-reset arbitration.
- Reset mid-operation (EXEC or RESP): in-flight operation is dropped; no rsp_valid after reset.
- Latency: accept at edge N -> EXEC in cycle N+1 -> rsp_valid high in cycle N+2.
- Throughput: back-to-back accept in RESP gives one operation per 2 cycles; otherwise 3 cycles.
- req_ready is combinational from req_valid, state, rr_ptr, and (in RESP) rsp_ready[owner].
- rsp_valid, rsp_out, rsp_flags, alu_* are register outputs (no combinational input path).

## Test plan
- Reset: hold rst_n low with random inputs -> all outputs 0; release with no requests -> remain 0.
- Single add: req 0 valid, src1=5, src2=7, aluc=0000, rsp_ready[0]=1 -> req_ready[0] cycle 0, rsp_valid[0] cycle 2, rsp_out=12, flags=0000; IDLE cycle 3.
- Overflow/flags: req 1, src1=0x7FFFFFFF, src2=1, aluc=0000 -> rsp_out=0x80000000, overflow=1, sign=1, zero=0, cout=0; sub 3-3 (aluc=0001) -> rsp_out=0, zero=1.
- Round-robin: both requesters continuously valid, rsp_ready all 1 -> grant order 0,1,0,1, each response to correct owner, one grant every 2 cycles.
- Backpressure: response to req 0 with rsp_ready[0]=0 for 3 cycles while req 1 valid -> rsp_valid[0] and rsp_out stable, req_ready all 0; rsp_ready[1]=1 alone has no effect; on rsp_ready[0]=1 req 1 is granted same cycle.
- Reset mid-EXEC: assert rst_n low during EXEC -> rsp_valid never asserted for that operation, alu_* return to 0 immediately.
